// File: rtl/div_serial.sv
// rtl/div_serial.sv - multicycle signed restoring divider with divide-by-zero exception
module div_serial #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  // Operand magnitudes; MIN_INT maps to 2**(WIDTH-1) as an unsigned value.
  logic             a_neg;
  logic             b_neg;
  logic             b_nonzero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign a_neg     = data_operandA[WIDTH-1];
  assign b_neg     = data_operandB[WIDTH-1];
  assign b_nonzero = |data_operandB;
  assign a_mag     = a_neg ? -data_operandA : data_operandA;
  assign b_mag     = b_neg ? -data_operandB : data_operandB;

  // Starts are only taken in IDLE outside the RDY cycle.
  logic accept;
  assign accept = (state_q == IDLE) && ctrl_DIV && !data_resultRDY;

  logic last_step;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = !diff[WIDTH];

  // Busy covers every non-IDLE state plus the RDY cycle itself.
  assign busy = (state_q != IDLE) || data_resultRDY;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = b_nonzero ? RUN : ZERO;
      RUN:  if (last_step) state_d = DONE;
      DONE: state_d = IDLE;
      ZERO: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      dvs_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvs_q     <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
          end
        end
        RUN: begin
          rem_q <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], fits};
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          data_result    <= neg_quo_q ? -quo_q : quo_q;
          data_remainder <= neg_rem_q ? -rem_q : rem_q;
          data_resultRDY <= 1'b1;
        end
        ZERO: begin
          data_result    <= '0;
          data_remainder <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_serial.sv
// tb/tb_div_serial.sv - scoreboard bench for div_serial with random and directed operands
module tb_div_serial;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_DIV;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] res;
  logic [W-1:0] rem;
  logic         rdy;
  logic         exc;
  logic         busy;

  div_serial #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
    .data_operandA(a), .data_operandB(b),
    .data_result(res), .data_remainder(rem),
    .data_resultRDY(rdy), .data_exception(exc), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           start;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic prev_rdy = 1'b0;
  exp_t mon_e;
  logic [W-1:0] idv;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero, remainder follows dividend.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint lq;
    longint lr;
    e.a = x;
    e.b = y;
    e.start = 0;
    e.due = 0;
    if (y == '0) begin
      e.q = '0;
      e.r = '0;
      e.e = 1'b1;
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lq = sx / sy;
      lr = sx % sy;
      e.q = lq[W-1:0];
      e.r = lr[W-1:0];
      e.e = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every RDY pulse and checks value, latency and identity.
  always @(negedge clock) begin
    if (rdy) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rdy", W'(rdy), W'(0));
      end else begin
        mon_e = sbq.pop_front();
        chk("quotient", res, mon_e.q);
        chk("remainder", rem, mon_e.r);
        chk("exception", W'(exc), W'(mon_e.e));
        chk("latency", W'(cyc - mon_e.start), W'(mon_e.due - mon_e.start));
        chk("busy_at_rdy", W'(busy), W'(1));
        if (!mon_e.e) begin
          idv = res * mon_e.b + rem;
          chk("identity", idv, mon_e.a);
        end
      end
    end else begin
      if (prev_rdy) begin
        chk("exc_clear", W'(exc), W'(0));
        chk("busy_clear", W'(busy), W'(0));
      end
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        chk("rdy_missing", W'(0), W'(1));
        void'(sbq.pop_front());
      end
    end
    prev_rdy = rdy;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", W'(busy), W'(0));
  endtask

  task automatic pulse(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    a = x;
    b = y;
    ctrl_DIV = 1'b1;
    if (push) begin
      e = model(x, y);
      e.start = cyc + 1;
      e.due = e.start + ((y == '0) ? 1 : W + 1);
      sbq.push_back(e);
    end
    tick();
    ctrl_DIV = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    pulse(x, y, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", W'(sbq.size()), W'(0));
    sbq.delete();
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = W'($urandom_range(0, 40)) - W'(20);
      2: v = $urandom >> $urandom_range(0, 31);
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h7FFF_FFFF;
          default: v = 32'h0000_0001;
        endcase
      end
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;
    reset = 1'b1;
    ctrl_DIV = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    chk("reset_result", res, '0);
    chk("reset_remainder", rem, '0);
    chk("reset_rdy", W'(rdy), W'(0));
    chk("reset_exc", W'(exc), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    reset = 1'b0;
    tick();

    // T1..T4
    run_op(32'd100, 32'd7);
    run_op(-32'd100, 32'd7);
    run_op(32'd100, -32'd7);
    run_op(32'd5, 32'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'd1);
    drain();

    // T5: start mid-operation and in the RDY cycle are ignored; next cycle is accepted
    run_op(32'd100, 32'd7);
    repeat (9) tick();
    pulse(32'd9, 32'd3, 1'b0);
    n = 0;
    while (!rdy && n < 100) begin
      tick();
      n++;
    end
    chk("t5_rdy_seen", W'(rdy), W'(1));
    pulse(32'd21, 32'd4, 1'b0);
    pulse(32'd50, 32'd7, 1'b1);
    drain();

    // T6: reset mid-operation aborts with no RDY
    run_op(32'd1234567, 32'd89);
    repeat (4) tick();
    reset = 1'b1;
    sbq.delete();
    tick();
    chk("t6_busy", W'(busy), W'(0));
    chk("t6_result", res, '0);
    chk("t6_remainder", rem, '0);
    chk("t6_rdy", W'(rdy), W'(0));
    reset = 1'b0;
    tick();
    run_op(-32'd77, 32'd5);
    drain();

    // Random operand pairs, about 5% zero divisors
    for (int i = 0; i < 1000; i++) begin
      ra = rand_val();
      if ($urandom_range(0, 99) < 5) begin
        rb = '0;
      end else begin
        rb = rand_val();
        if (rb == '0) rb = 32'd3;
      end
      run_op(ra, rb);
    end
    drain();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
